combo_lock_ctrl: RTL and testbench

- Parametrised sequential-code safe controller: N-stage code entry, configurable code width, saturating wrong-attempt counter, inactivity timeout, brute-force lockout and auto-relock.
- Sits between debounced switch/button inputs and the board display/LED drivers.
- Display formatting (BCD, 7-segment) stays outside; this block exports raw state and counts.

---
 rtl/combo_lock_pkg.sv | 20 ++
 rtl/combo_lock_ctrl_lock_timer.sv | 41 ++++
 rtl/combo_lock_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_combo_lock_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/combo_lock_pkg.sv
// Shared types and width helpers
// for the combination lock controller.
package combo_lock_pkg;

  typedef enum logic [1:0] {
    ST_PROG    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_LOCKOUT = 2'd2,
    ST_OPEN    = 2'd3
  } state_e;

  function automatic int clog2_min1(
    input int unsigned v
  );
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/combo_lock_ctrl_lock_timer.sv
// Loadable saturating down-counter
// with an expire flag at a fixed count.
module lock_timer #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] EXPIRE_AT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // load wins; otherwise count down and stick at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign expire_o = en_i & (cnt_q == EXPIRE_AT);

endmodule

// File: rtl/combo_lock_ctrl.sv
// Sequential-code safe controller:
// program, entry, lockout and open states.
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int N_CODES     = 3,
  parameter int CODE_W      = 6,
  parameter int T_MAX       = 50000000,
  parameter int MAX_TRIES   = 3,
  parameter int LOCKOUT_CYC = 100000000,
  parameter int CNT_W       = 10,
  parameter int STRICT      = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CODE_W-1:0]       code_in,
  input  logic                    enter_n,
  output logic [1:0]              state,
  output logic [clog2_min1(N_CODES)-1:0] stage,
  output logic [N_CODES-1:0]      progress,
  output logic [CNT_W-1:0]        incorrect_count,
  output logic [clog2_min1(LOCKOUT_CYC+1)-1:0]
                                  lockout_left,
  output logic                    timeout_pulse
);

  localparam int SW = clog2_min1(N_CODES);
  localparam int LW = clog2_min1(LOCKOUT_CYC + 1);
  localparam int TW = clog2_min1(T_MAX);
  localparam int FW = clog2_min1(MAX_TRIES + 1);

  localparam logic [SW-1:0] LAST   = SW'(N_CODES - 1);
  localparam logic [FW-1:0] FS_TOP = FW'(MAX_TRIES - 1);
  localparam logic [TW-1:0] T_LOAD = TW'(T_MAX - 1);
  localparam logic [LW-1:0] L_LOAD = LW'(LOCKOUT_CYC);

  state_e              state_q;
  logic [SW-1:0]       stage_q;
  logic [N_CODES-1:0]  progress_q;
  logic [CNT_W-1:0]    incorrect_q;
  logic [FW-1:0]       fail_q;
  logic [CODE_W-1:0]   slot_q [N_CODES];
  logic                tp_q;
  logic                enter_n_q;

  logic                press;
  logic                code_ok;
  logic                it_en;
  logic                it_load;
  logic                it_exp;
  logic [TW-1:0]       it_cnt_unused;
  logic                lo_en;
  logic                lo_load;
  logic                lo_exp;
  logic [LW-1:0]       lo_cnt;

  // button history for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_n_q <= 1'b1;
    end else begin
      enter_n_q <= enter_n;
    end
  end

  assign press   = enter_n_q & ~enter_n;
  assign code_ok = (code_in == slot_q[stage_q]);

  // inactivity runs in OPEN and mid-sequence ENTRY
  assign it_en   = (state_q == ST_OPEN) ||
                   (state_q == ST_ENTRY && stage_q != '0);
  assign it_load = ~it_en | press | it_exp;

  assign lo_en   = (state_q == ST_LOCKOUT);
  assign lo_load = (state_q == ST_ENTRY) & press &
                   ~code_ok & (fail_q == FS_TOP);

  lock_timer #(
    .WIDTH     (TW),
    .EXPIRE_AT ('0)
  ) u_idle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (it_load),
    .load_val_i (T_LOAD),
    .en_i       (it_en),
    .cnt_o      (it_cnt_unused),
    .expire_o   (it_exp)
  );

  lock_timer #(
    .WIDTH     (LW),
    .EXPIRE_AT (LW'(1))
  ) u_lock (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lo_load),
    .load_val_i (L_LOAD),
    .en_i       (lo_en),
    .cnt_o      (lo_cnt),
    .expire_o   (lo_exp)
  );

  // main controller: presses beat timeouts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PROG;
      stage_q     <= '0;
      progress_q  <= '0;
      incorrect_q <= '0;
      fail_q      <= '0;
      tp_q        <= 1'b0;
      for (int i = 0; i < N_CODES; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      tp_q <= 1'b0;
      unique case (state_q)
        ST_PROG: begin
          if (press) begin
            slot_q[stage_q] <= code_in;
            if (stage_q == LAST) begin
              state_q    <= ST_ENTRY;
              stage_q    <= '0;
              progress_q <= '0;
            end else begin
              progress_q[stage_q] <= 1'b1;
              stage_q <= stage_q + 1'b1;
            end
          end
        end
        ST_ENTRY: begin
          if (press && code_ok) begin
            fail_q <= '0;
            if (stage_q == LAST) begin
              state_q    <= ST_OPEN;
              stage_q    <= '0;
              progress_q <= '1;
            end else begin
              progress_q[stage_q] <= 1'b1;
              stage_q <= stage_q + 1'b1;
            end
          end else if (press) begin
            if (incorrect_q != '1) begin
              incorrect_q <= incorrect_q + 1'b1;
            end
            if (fail_q == FS_TOP) begin
              state_q    <= ST_LOCKOUT;
              fail_q     <= '0;
              stage_q    <= '0;
              progress_q <= '0;
            end else begin
              fail_q <= fail_q + 1'b1;
              if (STRICT != 0) begin
                stage_q    <= '0;
                progress_q <= '0;
              end
            end
          end else if (it_exp) begin
            stage_q    <= '0;
            progress_q <= '0;
            tp_q       <= 1'b1;
          end
        end
        ST_LOCKOUT: begin
          if (lo_exp) begin
            state_q    <= ST_ENTRY;
            stage_q    <= '0;
            progress_q <= '0;
          end
        end
        ST_OPEN: begin
          if (press) begin
            state_q     <= ST_PROG;
            stage_q     <= '0;
            progress_q  <= '0;
            incorrect_q <= '0;
            fail_q      <= '0;
            for (int i = 0; i < N_CODES; i++) begin
              slot_q[i] <= '0;
            end
          end else if (it_exp) begin
            state_q    <= ST_ENTRY;
            stage_q    <= '0;
            progress_q <= '0;
            tp_q       <= 1'b1;
          end
        end
      endcase
    end
  end

  assign state           = state_q;
  assign stage           = stage_q;
  assign progress        = progress_q;
  assign incorrect_count = incorrect_q;
  assign lockout_left    = lo_cnt;
  assign timeout_pulse   = tp_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Bench for combo_lock_ctrl: vector table
// plus timeout, relock, reset, strict runs.
module tb_combo_lock_ctrl;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] stg;
    logic [2:0] prog;
    logic [9:0] cnt;
    logic [3:0] ll;
    logic       tp;
  } out_t;

  typedef struct {
    bit         pr;
    logic [5:0] code;
    out_t       exp;
  } vec_t;

  localparam logic [1:0] P = 2'd0;
  localparam logic [1:0] E = 2'd1;
  localparam logic [1:0] L = 2'd2;
  localparam logic [1:0] O = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] code_in = '0;
  logic       enter_n = 1'b1;

  logic [1:0] st0, st1;
  logic [1:0] stg0, stg1;
  logic [2:0] pg0, pg1;
  logic [9:0] cnt0, cnt1;
  logic [3:0] ll0, ll1;
  logic       tp0, tp1;

  int checks = 0;
  int failures = 0;

  out_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  combo_lock_ctrl #(
    .N_CODES(3), .CODE_W(6), .T_MAX(16),
    .MAX_TRIES(3), .LOCKOUT_CYC(8),
    .CNT_W(10), .STRICT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .code_in(code_in), .enter_n(enter_n),
    .state(st0), .stage(stg0),
    .progress(pg0), .incorrect_count(cnt0),
    .lockout_left(ll0), .timeout_pulse(tp0)
  );

  combo_lock_ctrl #(
    .N_CODES(3), .CODE_W(6), .T_MAX(16),
    .MAX_TRIES(3), .LOCKOUT_CYC(8),
    .CNT_W(10), .STRICT(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n),
    .code_in(code_in), .enter_n(enter_n),
    .state(st1), .stage(stg1),
    .progress(pg1), .incorrect_count(cnt1),
    .lockout_left(ll1), .timeout_pulse(tp1)
  );

  function automatic out_t mk(
    input logic [1:0] st, input logic [1:0] stg,
    input logic [2:0] pg, input int cnt,
    input int ll, input bit tp
  );
    out_t o;
    o.st = st; o.stg = stg; o.prog = pg;
    o.cnt = 10'(cnt); o.ll = 4'(ll); o.tp = tp;
    return o;
  endfunction

  function automatic out_t s0();
    return mk(st0, stg0, pg0, int'(cnt0),
              int'(ll0), tp0);
  endfunction

  function automatic out_t s1();
    return mk(st1, stg1, pg1, int'(cnt1),
              int'(ll1), tp1);
  endfunction

  task automatic cmp(
    input string nm, input out_t g, input out_t w
  );
    checks++;
    if (g !== w) begin
      failures++;
      $display({"FAIL %s: got st=%0d stg=%0d prog=%b",
        " cnt=%0d ll=%0d tp=%0b want st=%0d stg=%0d",
        " prog=%b cnt=%0d ll=%0d tp=%0b"}, nm,
        g.st, g.stg, g.prog, g.cnt, g.ll, g.tp,
        w.st, w.stg, w.prog, w.cnt, w.ll, w.tp);
    end
  endtask

  task automatic step(
    input string nm, input bit pr,
    input int c, input out_t e
  );
    @(negedge clk);
    enter_n = ~pr;
    code_in = 6'(c);
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmp(nm, s0(), sb.pop_front());
  endtask

  task automatic idle(
    input string nm, input int n, input out_t e
  );
    for (int i = 0; i < n; i++) begin
      step(nm, 1'b0, 0, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enter_n = 1'b1;
    code_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic prog3();
    step("prog_a", 1, 12, mk(P, 1, 3'b001, 0, 0, 0));
    step("prog_a_r", 0, 0, mk(P, 1, 3'b001, 0, 0, 0));
    step("prog_b", 1, 34, mk(P, 2, 3'b011, 0, 0, 0));
    step("prog_b_r", 0, 0, mk(P, 2, 3'b011, 0, 0, 0));
    step("prog_c", 1, 56, mk(E, 0, 3'b000, 0, 0, 0));
    step("prog_c_r", 0, 0, mk(E, 0, 3'b000, 0, 0, 0));
  endtask

  function automatic void add(
    input bit pr, input int c,
    input logic [1:0] st, input logic [1:0] stg,
    input logic [2:0] pg, input int cnt, input int ll
  );
    vec_t v;
    v.pr = pr;
    v.code = 6'(c);
    v.exp = mk(st, stg, pg, cnt, ll, 1'b0);
    vecs.push_back(v);
  endfunction

  function automatic void add_prog(input int cnt);
    add(1, 12, P, 1, 3'b001, cnt, 0);
    add(0, 0,  P, 1, 3'b001, cnt, 0);
    add(1, 34, P, 2, 3'b011, cnt, 0);
    add(0, 0,  P, 2, 3'b011, cnt, 0);
    add(1, 56, E, 0, 3'b000, cnt, 0);
    add(0, 0,  E, 0, 3'b000, cnt, 0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    cmp("reset", s0(), mk(P, 0, 3'b000, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // program and open
    add_prog(0);
    add(1, 12, E, 1, 3'b001, 0, 0);
    add(0, 0,  E, 1, 3'b001, 0, 0);
    add(1, 34, E, 2, 3'b011, 0, 0);
    add(0, 0,  E, 2, 3'b011, 0, 0);
    add(1, 56, O, 0, 3'b111, 0, 0);
    add(0, 0,  O, 0, 3'b111, 0, 0);
    add(1, 0,  P, 0, 3'b000, 0, 0);
    add(0, 0,  P, 0, 3'b000, 0, 0);
    // held button counts once
    add(1, 12, P, 1, 3'b001, 0, 0);
    add(1, 12, P, 1, 3'b001, 0, 0);
    add(0, 0,  P, 1, 3'b001, 0, 0);
    add(1, 34, P, 2, 3'b011, 0, 0);
    add(0, 0,  P, 2, 3'b011, 0, 0);
    add(1, 56, E, 0, 3'b000, 0, 0);
    add(0, 0,  E, 0, 3'b000, 0, 0);
    // wrong then right
    add(1, 12, E, 1, 3'b001, 0, 0);
    add(0, 0,  E, 1, 3'b001, 0, 0);
    add(1, 7,  E, 1, 3'b001, 1, 0);
    add(0, 0,  E, 1, 3'b001, 1, 0);
    add(1, 34, E, 2, 3'b011, 1, 0);
    add(0, 0,  E, 2, 3'b011, 1, 0);
    add(1, 56, O, 0, 3'b111, 1, 0);
    add(0, 0,  O, 0, 3'b111, 1, 0);
    add(1, 0,  P, 0, 3'b000, 0, 0);
    add(0, 0,  P, 0, 3'b000, 0, 0);
    add_prog(0);
    // lockout
    add(1, 7,  E, 0, 3'b000, 1, 0);
    add(0, 0,  E, 0, 3'b000, 1, 0);
    add(1, 7,  E, 0, 3'b000, 2, 0);
    add(0, 0,  E, 0, 3'b000, 2, 0);
    add(1, 7,  L, 0, 3'b000, 3, 8);
    add(0, 0,  L, 0, 3'b000, 3, 7);
    add(1, 12, L, 0, 3'b000, 3, 6);
    add(0, 0,  L, 0, 3'b000, 3, 5);
    add(0, 0,  L, 0, 3'b000, 3, 4);
    add(0, 0,  L, 0, 3'b000, 3, 3);
    add(0, 0,  L, 0, 3'b000, 3, 2);
    add(0, 0,  L, 0, 3'b000, 3, 1);
    add(1, 12, E, 0, 3'b000, 3, 0);
    add(0, 0,  E, 0, 3'b000, 3, 0);
    add(1, 12, E, 1, 3'b001, 3, 0);
    add(0, 0,  E, 1, 3'b001, 3, 0);

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].pr,
           int'(vecs[i].code), vecs[i].exp);
    end

    // inactivity timeout
    do_reset();
    prog3();
    step("to_press", 1, 12, mk(E, 1, 3'b001, 0, 0, 0));
    idle("to_wait", 15, mk(E, 1, 3'b001, 0, 0, 0));
    step("to_fire", 0, 0, mk(E, 0, 3'b000, 0, 0, 1));
    step("to_clr", 0, 0, mk(E, 0, 3'b000, 0, 0, 0));
    idle("to_st0", 20, mk(E, 0, 3'b000, 0, 0, 0));
    // press on expiry cycle wins
    step("tw_press", 1, 12, mk(E, 1, 3'b001, 0, 0, 0));
    idle("tw_wait", 15, mk(E, 1, 3'b001, 0, 0, 0));
    step("tw_race", 1, 34, mk(E, 2, 3'b011, 0, 0, 0));
    step("tw_after", 0, 0, mk(E, 2, 3'b011, 0, 0, 0));

    // auto-relock then reprogram
    step("rl_open", 1, 56, mk(O, 0, 3'b111, 0, 0, 0));
    idle("rl_wait", 15, mk(O, 0, 3'b111, 0, 0, 0));
    step("rl_fire", 0, 0, mk(E, 0, 3'b000, 0, 0, 1));
    step("rl_bad", 1, 7, mk(E, 0, 3'b000, 1, 0, 0));
    step("rl_bad_r", 0, 0, mk(E, 0, 3'b000, 1, 0, 0));
    step("rl_a", 1, 12, mk(E, 1, 3'b001, 1, 0, 0));
    step("rl_a_r", 0, 0, mk(E, 1, 3'b001, 1, 0, 0));
    step("rl_b", 1, 34, mk(E, 2, 3'b011, 1, 0, 0));
    step("rl_b_r", 0, 0, mk(E, 2, 3'b011, 1, 0, 0));
    step("rl_c", 1, 56, mk(O, 0, 3'b111, 1, 0, 0));
    step("rl_c_r", 0, 0, mk(O, 0, 3'b111, 1, 0, 0));
    step("rl_prog", 1, 0, mk(P, 0, 3'b000, 0, 0, 0));
    step("rl_prog_r", 0, 0, mk(P, 0, 3'b000, 0, 0, 0));

    // asynchronous reset mid-entry
    do_reset();
    prog3();
    step("ar_a", 1, 12, mk(E, 1, 3'b001, 0, 0, 0));
    step("ar_a_r", 0, 0, mk(E, 1, 3'b001, 0, 0, 0));
    step("ar_b", 1, 34, mk(E, 2, 3'b011, 0, 0, 0));
    #1;
    rst_n = 1'b0;
    enter_n = 1'b1;
    #1;
    cmp("async_rst", s0(), mk(P, 0, 3'b000, 0, 0, 0));
    cmp("async_rst_s", s1(), mk(P, 0, 3'b000, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // strict variant drops to stage 0
    prog3();
    step("st_a", 1, 12, mk(E, 1, 3'b001, 0, 0, 0));
    step("st_a_r", 0, 0, mk(E, 1, 3'b001, 0, 0, 0));
    step("st_b", 1, 34, mk(E, 2, 3'b011, 0, 0, 0));
    step("st_b_r", 0, 0, mk(E, 2, 3'b011, 0, 0, 0));
    cmp("strict_pre", s1(), mk(E, 2, 3'b011, 0, 0, 0));
    step("st_bad", 1, 7, mk(E, 2, 3'b011, 1, 0, 0));
    cmp("strict_bad", s1(), mk(E, 0, 3'b000, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
